// File: rtl/exu_muldiv.sv
// rtl/exu_muldiv.sv - iterative RV M-extension multiply/divide execute unit
module exu_muldiv #(
    parameter int XLEN     = 64,
    parameter int ENABLE_W = 1,
    parameter int TAG_W    = 5
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [3:0]       op_i,
    input  logic [XLEN-1:0]  src1_i,
    input  logic [XLEN-1:0]  src2_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [XLEN-1:0]  res_o,
    output logic [TAG_W-1:0] tag_o,
    output logic             busy_o
);

    localparam logic W_EN = (XLEN == 64) && (ENABLE_W != 0);
    localparam int   CW   = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q;
    logic              is_div_q, is_rem_q, mul_hi_q, w_q, neg_q;
    logic [2*XLEN-1:0] acc_q, b_q;
    logic [XLEN-1:0]   mq_q, res_q;
    logic [TAG_W-1:0]  tag_q;

    // Sign- or zero-extend the low word when a W op is in effect.
    function automatic logic [XLEN-1:0] ext32(input logic [XLEN-1:0] x, input logic sgn, input logic w);
        ext32 = x;
        if (w) begin
            for (int i = 32; i < XLEN; i++) ext32[i] = sgn & x[31];
        end
    endfunction

    logic [2:0]      fn;
    logic            w_in, is_div_in, sgn1, sgn2, s1, s2, div0, ovf, special, neg_in, accept;
    logic [XLEN-1:0] ext1, ext2, mag1, mag2, special_res;

    always_comb begin
        w_in        = W_EN && op_i[3];
        fn          = (w_in && !op_i[2]) ? 3'd0 : op_i[2:0];
        is_div_in   = fn[2];
        sgn1        = (fn == 3'd1) || (fn == 3'd2) || (fn[2] && !fn[0]);
        sgn2        = (fn == 3'd1) || (fn[2] && !fn[0]);
        ext1        = ext32(src1_i, sgn1, w_in);
        ext2        = ext32(src2_i, sgn2, w_in);
        s1          = sgn1 && ext1[XLEN-1];
        s2          = sgn2 && ext2[XLEN-1];
        mag1        = s1 ? ('0 - ext1) : ext1;
        mag2        = s2 ? ('0 - ext2) : ext2;
        div0        = (ext2 == '0);
        ovf         = sgn2 && (ext2 == '1) &&
                      (w_in ? (src1_i[31:0] == 32'h8000_0000) : (src1_i == {1'b1, {(XLEN-1){1'b0}}}));
        special     = is_div_in && (div0 || ovf);
        if (div0) special_res = fn[1] ? ext32(src1_i, 1'b1, w_in) : '1;
        else      special_res = fn[1] ? '0 : ext32(src1_i, 1'b1, w_in);
        neg_in      = (is_div_in && fn[1]) ? s1 : (s1 ^ s2);
        accept      = (state_q == IDLE) && in_valid_i && !flush_i;
    end

    logic [2*XLEN-1:0] acc_nx, b_nx, prod;
    logic [XLEN-1:0]   mq_nx, mul_r, qr, div_r, fin;
    logic [XLEN:0]     r_sh, sub;
    logic              qbit;

    // One iteration: shift-add for multiply, restoring step for divide.
    always_comb begin
        r_sh = {acc_q[XLEN-1:0], mq_q[XLEN-1]};
        sub  = r_sh - {1'b0, b_q[XLEN-1:0]};
        qbit = (r_sh >= {1'b0, b_q[XLEN-1:0]});
        if (is_div_q) begin
            acc_nx = {{(XLEN-1){1'b0}}, (qbit ? sub : r_sh)};
            b_nx   = b_q;
            mq_nx  = {mq_q[XLEN-2:0], qbit};
        end else begin
            acc_nx = acc_q + (mq_q[0] ? b_q : '0);
            b_nx   = b_q << 1;
            mq_nx  = mq_q >> 1;
        end
        prod  = neg_q ? ('0 - acc_nx) : acc_nx;
        mul_r = mul_hi_q ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
        qr    = is_rem_q ? acc_nx[XLEN-1:0] : mq_nx;
        div_r = neg_q ? ('0 - qr) : qr;
        fin   = ext32(is_div_q ? div_r : mul_r, 1'b1, w_q);
    end

    always_ff @(posedge clock) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = special ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    if (out_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i) state_d = IDLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q    <= '0;
            is_div_q <= 1'b0;
            is_rem_q <= 1'b0;
            mul_hi_q <= 1'b0;
            w_q      <= 1'b0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            b_q      <= '0;
            mq_q     <= '0;
            res_q    <= '0;
            tag_q    <= '0;
        end else if (accept) begin
            cnt_q    <= w_in ? CW'(31) : CW'(XLEN-1);
            is_div_q <= is_div_in;
            is_rem_q <= fn[2] && fn[1];
            mul_hi_q <= !fn[2] && (fn != 3'd0);
            w_q      <= w_in;
            neg_q    <= neg_in;
            acc_q    <= '0;
            b_q      <= {{XLEN{1'b0}}, (is_div_in ? mag2 : mag1)};
            // Divide shifts the dividend out of the MSB, so a W dividend is pre-aligned to the top.
            mq_q     <= is_div_in ? (w_in ? (mag1 << (XLEN-32)) : mag1) : mag2;
            tag_q    <= tag_i;
            if (special) res_q <= special_res;
        end else if (state_q == CALC) begin
            cnt_q <= cnt_q - CW'(1);
            acc_q <= acc_nx;
            b_q   <= b_nx;
            mq_q  <= mq_nx;
            if (cnt_q == '0) res_q <= fin;
        end
    end

    assign in_ready_o  = (state_q == IDLE);
    assign busy_o      = (state_q != IDLE);
    assign out_valid_o = (state_q == DONE);
    assign res_o       = res_q;
    assign tag_o       = tag_q;

endmodule

// File: tb/tb_exu_muldiv.sv
// tb/tb_exu_muldiv.sv - directed vector bench for exu_muldiv
module tb_exu_muldiv;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [3:0]  op = '0;
    logic [63:0] src1 = '0;
    logic [63:0] src2 = '0;
    logic [4:0]  tag = '0;
    logic        in_ready, out_valid, busy;
    logic [63:0] res;
    logic [4:0]  tag_out;

    exu_muldiv #(.XLEN(64), .ENABLE_W(1), .TAG_W(5)) dut (
        .clock       (clock),
        .reset       (reset),
        .flush_i     (flush),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .src1_i      (src1),
        .src2_i      (src2),
        .tag_i       (tag),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .res_o       (res),
        .tag_o       (tag_out),
        .busy_o      (busy)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    typedef struct {
        logic [3:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  tag;
        logic [63:0] res;
        int          lat;
    } vec_t;

    vec_t vecs[18];

    task automatic issue(input logic [3:0] o, input logic [63:0] a, input logic [63:0] b, input logic [4:0] t);
        @(negedge clock);
        op = o; src1 = a; src2 = b; tag = t; in_valid = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        do begin
            @(negedge clock);
            lat++;
        end while (!out_valid && lat < 200);
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
    endtask

    int lat;
    logic seen;

    initial begin
        vecs[0]  = '{4'd0,  64'd7,                 64'hFFFF_FFFF_FFFF_FFFD, 5'h03, 64'hFFFF_FFFF_FFFF_FFEB, 65};
        vecs[1]  = '{4'd3,  64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'h04, 64'hFFFF_FFFF_FFFF_FFFE, 65};
        vecs[2]  = '{4'd2,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,                 5'h05, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[3]  = '{4'd4,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 5'h06, 64'hFFFF_FFFF_FFFF_FFFD, 65};
        vecs[4]  = '{4'd6,  64'hFFFF_FFFF_FFFF_FFF9, 64'd2,                 5'h07, 64'hFFFF_FFFF_FFFF_FFFF, 65};
        vecs[5]  = '{4'd5,  64'd123,               64'd0,                 5'h08, 64'hFFFF_FFFF_FFFF_FFFF, 1};
        vecs[6]  = '{4'd4,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'h09, 64'h8000_0000_0000_0000, 1};
        vecs[7]  = '{4'd12, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'h0A, 64'hFFFF_FFFF_8000_0000, 1};
        vecs[8]  = '{4'd8,  64'h0000_0000_7FFF_FFFF, 64'd2,                 5'h0B, 64'hFFFF_FFFF_FFFF_FFFE, 33};
        vecs[9]  = '{4'd7,  64'd100,               64'd7,                 5'h0C, 64'd2,                  65};
        vecs[10] = '{4'd5,  64'd100,               64'd7,                 5'h0D, 64'd14,                 65};
        vecs[11] = '{4'd6,  64'hFFFF_FFFF_FFFF_FFFB, 64'd0,                 5'h0E, 64'hFFFF_FFFF_FFFF_FFFB, 1};
        vecs[12] = '{4'd6,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'h0F, 64'd0,                  1};
        vecs[13] = '{4'd1,  64'h4000_0000_0000_0000, 64'd4,                 5'h10, 64'd1,                  65};
        vecs[14] = '{4'd14, 64'h1234_5678_FFFF_FFF9, 64'd2,                 5'h11, 64'hFFFF_FFFF_FFFF_FFFF, 33};
        vecs[15] = '{4'd13, 64'hABCD_EF01_FFFF_FFFF, 64'd2,                 5'h12, 64'h0000_0000_7FFF_FFFF, 33};
        vecs[16] = '{4'd9,  64'd3,                 64'd5,                 5'h13, 64'd15,                 33};
        vecs[17] = '{4'd15, 64'hABCD_0000_8000_0005, 64'hFFFF_FFFF_0000_0000, 5'h14, 64'hFFFF_FFFF_8000_0005, 1};

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_res", res, 64'd0);
        check("rst_tag", {59'd0, tag_out}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_in_ready", {63'd0, in_ready}, 64'd1);

        for (int i = 0; i < 18; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].tag);
            wait_valid(lat);
            check($sformatf("vec%0d_res", i), res, vecs[i].res);
            check($sformatf("vec%0d_tag", i), {59'd0, tag_out}, {59'd0, vecs[i].tag});
            check($sformatf("vec%0d_lat", i), 64'(lat), 64'(vecs[i].lat));
            consume();
        end

        // Backpressure: result and tag held, no new request accepted
        issue(4'd8, 64'h0000_0000_7FFF_FFFF, 64'd2, 5'h1A);
        wait_valid(lat);
        check("hold_lat", 64'(lat), 64'd33);
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            check($sformatf("hold%0d_res", k), res, 64'hFFFF_FFFF_FFFF_FFFE);
            check($sformatf("hold%0d_in_ready", k), {63'd0, in_ready}, 64'd0);
        end
        consume();
        check("hold_released_valid", {63'd0, out_valid}, 64'd0);
        check("hold_released_ready", {63'd0, in_ready}, 64'd1);

        // Request together with flush in IDLE is not accepted
        @(negedge clock);
        op = 4'd0; src1 = 64'd2; src2 = 64'd3; in_valid = 1'b1; flush = 1'b1;
        @(posedge clock);
        #1 in_valid = 1'b0; flush = 1'b0;
        check("flush_req_busy", {63'd0, busy}, 64'd0);

        // Flush at iteration 10 of a DIV
        issue(4'd4, 64'd1000, 64'd3, 5'h15);
        repeat (10) @(negedge clock);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        check("flush_in_ready", {63'd0, in_ready}, 64'd1);
        check("flush_busy", {63'd0, busy}, 64'd0);
        seen = 1'b0;
        repeat (80) begin
            @(negedge clock);
            if (out_valid) seen = 1'b1;
        end
        check("flush_no_valid", {63'd0, seen}, 64'd0);
        issue(4'd0, 64'd6, 64'd7, 5'h16);
        wait_valid(lat);
        check("post_flush_res", res, 64'd42);
        check("post_flush_tag", {59'd0, tag_out}, 64'h16);
        check("post_flush_lat", 64'(lat), 64'd65);
        consume();

        // Reset mid-CALC
        issue(4'd0, 64'd9, 64'd9, 5'h17);
        repeat (20) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1 reset = 1'b0;
        check("midrst_out_valid", {63'd0, out_valid}, 64'd0);
        check("midrst_res", res, 64'd0);
        check("midrst_tag", {59'd0, tag_out}, 64'd0);
        check("midrst_busy", {63'd0, busy}, 64'd0);
        check("midrst_in_ready", {63'd0, in_ready}, 64'd1);

        // Flush while a result waits in DONE
        issue(4'd5, 64'd55, 64'd0, 5'h18);
        wait_valid(lat);
        check("done_flush_lat", 64'(lat), 64'd1);
        flush = 1'b1;
        @(posedge clock);
        #1 flush = 1'b0;
        check("done_flush_valid", {63'd0, out_valid}, 64'd0);
        check("done_flush_ready", {63'd0, in_ready}, 64'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
